reg_wb_scheduler: RTL and testbench

//  Schedules writes into the single write port of the 32x32 register file.

---
 rtl/reg_wb_scheduler.sv | 170 +++++++++++++++++
 tb/tb_reg_wb_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_scheduler.sv
// reg_wb_scheduler
//   Arbitrates the single register-file write port between the ALU result
//   path and an in-order, variable-latency load unit. Every outstanding
//   load destination is tracked in a small FIFO so that decode can be
//   stalled on RAW/WAW hazards against pending loads.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   alu_wb_*            ALU writeback request {valid, rd, data}
//   ld_issue_*          load issue handshake; rd is enqueued on accept
//   ld_resp_*           load response handshake (oldest outstanding load)
//   rs1_addr/rs2_addr   decode source registers for hazard detection
//   stall               hold decode and suppress ALU writeback
//   rf_we/waddr/wdata   register file write port (address/data zero when idle)
//   ld_pending          outstanding loads including the hold entry
//   err_orphan          sticky: a response arrived with no outstanding load
module reg_wb_scheduler #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int LD_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_wb_valid,
    input  logic [AW-1:0]               alu_wb_rd,
    input  logic [XLEN-1:0]             alu_wb_data,
    input  logic                        ld_issue_valid,
    input  logic [AW-1:0]               ld_issue_rd,
    output logic                        ld_issue_ready,
    input  logic                        ld_resp_valid,
    input  logic [XLEN-1:0]             ld_resp_data,
    output logic                        ld_resp_ready,
    input  logic [AW-1:0]               rs1_addr,
    input  logic [AW-1:0]               rs2_addr,
    output logic                        stall,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [$clog2(LD_DEPTH):0]   ld_pending,
    output logic                        err_orphan
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   r_fifo [LD_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_hold_valid;
    logic [AW-1:0]   r_hold_rd;
    logic [XLEN-1:0] r_hold_data;
    logic            r_err_orphan;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_accept;
    logic                w_pop;
    logic                w_orphan;
    logic [AW-1:0]       w_head_rd;
    logic [LD_DEPTH-1:0] w_valid;
    logic                w_m1;
    logic                w_m2;
    logic                w_ma;
    logic                w_alu_go;
    logic                w_sel;
    logic [AW-1:0]       w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;

    assign w_full    = (r_count == CW'(LD_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = ld_issue_valid && !w_full;
    assign w_accept  = ld_resp_valid && !r_hold_valid;
    assign w_pop     = w_accept && !w_empty;
    assign w_orphan  = w_accept && w_empty;
    assign w_head_rd = r_fifo[r_rd_ptr];

    assign ld_issue_ready = !w_full;
    assign ld_resp_ready  = !r_hold_valid;
    assign ld_pending     = r_count + CW'(r_hold_valid);
    assign err_orphan     = r_err_orphan;

    // An entry is live when its distance from the read pointer (mod depth)
    // is below the count; stale slots left behind by pops never match.
    // The head being popped this cycle still counts as live.
    always_comb begin
        w_valid = '0;
        w_m1    = 1'b0;
        w_m2    = 1'b0;
        w_ma    = 1'b0;
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            w_valid[i] = ({1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count);
            if (w_valid[i]) begin
                if (r_fifo[i] == rs1_addr)  w_m1 = 1'b1;
                if (r_fifo[i] == rs2_addr)  w_m2 = 1'b1;
                if (r_fifo[i] == alu_wb_rd) w_ma = 1'b1;
            end
        end
        if (r_hold_valid) begin
            if (r_hold_rd == rs1_addr)  w_m1 = 1'b1;
            if (r_hold_rd == rs2_addr)  w_m2 = 1'b1;
            if (r_hold_rd == alu_wb_rd) w_ma = 1'b1;
        end
        w_m1 = w_m1 && (rs1_addr  != '0);
        w_m2 = w_m2 && (rs2_addr  != '0);
        w_ma = w_ma && (alu_wb_rd != '0);
    end

    assign stall    = w_m1 | w_m2 | (alu_wb_valid & w_ma);
    assign w_alu_go = alu_wb_valid && !stall;

    // Write-port priority: ALU, then held load, then a directly accepted load.
    always_comb begin
        w_sel      = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_alu_go) begin
            w_sel      = 1'b1;
            w_sel_rd   = alu_wb_rd;
            w_sel_data = alu_wb_data;
        end else if (r_hold_valid) begin
            w_sel      = 1'b1;
            w_sel_rd   = r_hold_rd;
            w_sel_data = r_hold_data;
        end else if (w_pop) begin
            w_sel      = 1'b1;
            w_sel_rd   = w_head_rd;
            w_sel_data = ld_resp_data;
        end
    end

    // x0 writes consume their slot but never reach the register file.
    assign rf_we    = w_sel && (w_sel_rd != '0);
    assign rf_waddr = rf_we ? w_sel_rd   : '0;
    assign rf_wdata = rf_we ? w_sel_data : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= ld_issue_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // Hold only fills when the ALU owns the port while a load pops;
            // it drains on the first cycle the ALU leaves the port free.
            if (w_alu_go && w_pop) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= w_head_rd;
                r_hold_data  <= ld_resp_data;
            end else if (!w_alu_go && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end
            if (w_orphan) r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
module tb_reg_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  ld_pending;
    logic        err_orphan;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    reg_wb_scheduler #(.XLEN(32), .AW(5), .LD_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_rd      (alu_wb_rd),
        .alu_wb_data    (alu_wb_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_ready  (ld_resp_ready),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .stall          (stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .ld_pending     (ld_pending),
        .err_orphan     (err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle();
        alu_wb_valid   = 1'b0;
        alu_wb_rd      = '0;
        alu_wb_data    = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
    endtask

    // Settle, check write port against the scoreboard, advance one cycle.
    task automatic tick(input logic exp_we);
        wr_t e;
        #1;
        chk("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
        if (rf_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", {63'd0, rf_we}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {59'd0, rf_waddr}, {59'd0, e.rd});
                chk("wr_data", {32'd0, rf_wdata}, {32'd0, e.data});
            end
        end else begin
            chk("idle_addr", {59'd0, rf_waddr}, 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_issue_ready", {63'd0, ld_issue_ready}, 64'd1);
        chk("rst_resp_ready",  {63'd0, ld_resp_ready},  64'd1);
        chk("rst_stall",       {63'd0, stall},          64'd0);
        chk("rst_we",          {63'd0, rf_we},          64'd0);
        chk("rst_wdata",       {32'd0, rf_wdata},       64'd0);
        chk("rst_pending",     {61'd0, ld_pending},     64'd0);
        chk("rst_orphan",      {63'd0, err_orphan},     64'd0);
        rst = 1'b0;

        // 1: plain ALU writeback
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        #1 chk("t1_stall", {63'd0, stall}, 64'd0);
        tick(1'b1);
        idle();

        // 2: RAW stall on pending load
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; rs1_addr = 5'd7;
        #1 chk("t2_stall_issue", {63'd0, stall}, 64'd0);
        tick(1'b0);
        idle();
        #1 chk("t2_stall_pend", {63'd0, stall}, 64'd1);
        chk("t2_pending", {61'd0, ld_pending}, 64'd1);
        tick(1'b0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h1234;
        expect_wr(5'd7, 32'h1234);
        #1 chk("t2_stall_pop", {63'd0, stall}, 64'd1);
        tick(1'b1);
        idle();
        #1 chk("t2_stall_clear", {63'd0, stall}, 64'd0);
        chk("t2_pending0", {61'd0, ld_pending}, 64'd0);
        tick(1'b0);
        rs1_addr = '0;

        // 3: ALU and load collide, load parks in hold
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        tick(1'b0);
        idle();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'hA;
        ld_resp_valid = 1'b1; ld_resp_data = 32'hB;
        expect_wr(5'd3, 32'hA);
        expect_wr(5'd9, 32'hB);
        tick(1'b1);
        idle();
        #1 chk("t3_resp_ready", {63'd0, ld_resp_ready}, 64'd0);
        chk("t3_pending_hold", {61'd0, ld_pending}, 64'd1);
        tick(1'b1);
        #1 chk("t3_resp_ready2", {63'd0, ld_resp_ready}, 64'd1);
        chk("t3_pending0", {61'd0, ld_pending}, 64'd0);

        // 4: fill FIFO, overflow attempt, drain, stale entries, wrap refill
        for (int i = 1; i <= 4; i++) begin
            ld_issue_valid = 1'b1; ld_issue_rd = 5'(i);
            tick(1'b0);
        end
        #1 chk("t4_issue_ready", {63'd0, ld_issue_ready}, 64'd0);
        chk("t4_pending4", {61'd0, ld_pending}, 64'd4);
        ld_issue_rd = 5'd10;
        tick(1'b0);
        idle();
        #1 chk("t4_pending_still4", {61'd0, ld_pending}, 64'd4);
        for (int i = 1; i <= 4; i++) begin
            ld_resp_valid = 1'b1; ld_resp_data = 32'h100 + 32'(i);
            expect_wr(5'(i), 32'h100 + 32'(i));
            tick(1'b1);
        end
        idle();
        rs1_addr = 5'd1; rs2_addr = 5'd10;
        #1 chk("t4_stale_nostall", {63'd0, stall}, 64'd0);
        chk("t4_pending0", {61'd0, ld_pending}, 64'd0);
        rs1_addr = '0; rs2_addr = '0;
        for (int i = 11; i <= 14; i++) begin
            ld_issue_valid = 1'b1; ld_issue_rd = 5'(i);
            tick(1'b0);
        end
        idle();
        rs2_addr = 5'd13;
        #1 chk("t4_wrap_stall", {63'd0, stall}, 64'd1);
        rs2_addr = '0;
        for (int i = 11; i <= 14; i++) begin
            ld_resp_valid = 1'b1; ld_resp_data = 32'h200 + 32'(i);
            expect_wr(5'(i), 32'h200 + 32'(i));
            tick(1'b1);
        end
        idle();

        // simultaneous push+pop, and WAW stall suppressing ALU
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd20;
        tick(1'b0);
        ld_issue_rd = 5'd21; ld_resp_valid = 1'b1; ld_resp_data = 32'h20;
        expect_wr(5'd20, 32'h20);
        tick(1'b1);
        idle();
        #1 chk("t4_pushpop_pending", {61'd0, ld_pending}, 64'd1);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd21; alu_wb_data = 32'hBAD;
        #1 chk("t4_waw_stall", {63'd0, stall}, 64'd1);
        tick(1'b0);
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h21;
        expect_wr(5'd21, 32'h21);
        tick(1'b1);
        idle();

        // 5: load to x0
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        tick(1'b0);
        idle();
        #1 chk("t5_pending1", {61'd0, ld_pending}, 64'd1);
        chk("t5_x0_nostall", {63'd0, stall}, 64'd0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h55;
        tick(1'b0);
        idle();
        #1 chk("t5_pending0", {61'd0, ld_pending}, 64'd0);

        // 6: orphan response, then reset with loads pending
        chk("t6_orphan_pre", {63'd0, err_orphan}, 64'd0);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        tick(1'b0);
        idle();
        #1 chk("t6_orphan", {63'd0, err_orphan}, 64'd1);
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd6;
        tick(1'b0);
        ld_issue_rd = 5'd8;
        tick(1'b0);
        idle();
        rs1_addr = 5'd6;
        #1 chk("t6_stall_pre", {63'd0, stall}, 64'd1);
        chk("t6_pending2", {61'd0, ld_pending}, 64'd2);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        #1 chk("t6_pending_rst", {61'd0, ld_pending}, 64'd0);
        chk("t6_orphan_rst", {63'd0, err_orphan}, 64'd0);
        chk("t6_stall_rst", {63'd0, stall}, 64'd0);
        rs1_addr = '0;

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
